// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_VAL    = 4'd3;

  // Smallest digit count whose decimal range covers every BIN_W-bit value.
  function automatic int unsigned min_digits(int unsigned bin_w);
    longint unsigned max_val;
    longint unsigned pow10;
    int unsigned     d;
    max_val = (64'd1 << bin_w) - 64'd1;
    pow10   = 64'd10;
    d       = 1;
    while (pow10 <= max_val) begin
      d     = d + 1;
      pow10 = pow10 * 64'd10;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: adds 3 to a BCD digit of 5 or more.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  assign corrected = (digit >= ADD3_THRESH) ? digit + ADD3_VAL : digit;

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-cycle binary-to-BCD converter: one shift-and-add-3 step per clock,
// valid/ready handshakes on both sides.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                busy
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  if (BIN_W < 4 || BIN_W > 16) begin : g_bad_bin_w
    $fatal(1, "bcd_seq_converter: BIN_W=%0d outside 4..16", BIN_W);
  end
  if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
    $fatal(1, "bcd_seq_converter: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [SR_W-1:0]    sr_corr, sr_shift;
  logic [BCD_W-1:0]   bcd_corr;
  logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;
  logic               last_shift;

  // All digits are corrected from the current register value before the shift.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_add3_digit u_add3 (
      .digit     (sr_q[BIN_W + 4*i +: 4]),
      .corrected (bcd_corr[4*i +: 4])
    );
  end

  assign sr_corr    = {bcd_corr, sr_q[BIN_W-1:0]};
  assign sr_shift   = sr_corr << 1;
  assign last_shift = (cnt_q == CNT_W'(BIN_W - 1));

  // Combinational from out_ready so a finished result and a new input can swap on one edge.
  assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StShift);
  assign out_bcd   = out_bcd_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    out_bcd_d = out_bcd_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          sr_d    = {{BCD_W{1'b0}}, in_data};
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_shift) begin
          out_bcd_d = sr_shift[SR_W-1 -: BCD_W];
          state_d   = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          if (in_valid) begin
            sr_d    = {{BCD_W{1'b0}}, in_data};
            cnt_d   = '0;
            state_d = StShift;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sr_q      <= '0;
      out_bcd_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      out_bcd_q <= out_bcd_d;
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed and table-driven checks of bcd_seq_converter (8-bit default and a 10-bit build).
module tb_bcd_seq_converter;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  in_data;
  logic [11:0] out_bcd;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
  logic [9:0]  w_in_data;
  logic [15:0] w_out_bcd;

  int tests;
  int fails;

  bcd_seq_converter #(.BIN_W(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .busy      (busy)
  );

  bcd_seq_converter #(.BIN_W(10), .DIGITS(4)) dut_wide (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_data   (w_in_data),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out_bcd   (w_out_bcd),
    .busy      (w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  value;
    logic [11:0] bcd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    int p;
    p = 1;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Starts from IDLE, accepts one value, waits for the result and drains it.
  task automatic convert(input logic [7:0] value, output logic [11:0] res, output int lat);
    in_data   = value;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    res = out_bcd;
    @(posedge clk); #1;
  endtask

  logic [11:0] res;
  int          lat;
  logic [11:0] seq_exp[3];
  logic [7:0]  seq_in[3];
  logic        stable;

  initial begin
    tests = 0;
    fails = 0;
    vecs[0] = '{8'd0,   12'h000};
    vecs[1] = '{8'd9,   12'h009};
    vecs[2] = '{8'd10,  12'h010};
    vecs[3] = '{8'd99,  12'h099};
    vecs[4] = '{8'd100, 12'h100};
    vecs[5] = '{8'd128, 12'h128};
    vecs[6] = '{8'd199, 12'h199};
    vecs[7] = '{8'd200, 12'h200};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b1;
    #2;
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_out_bcd", 32'(out_bcd), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", 32'(in_ready), 1);

    // 255: latency and busy during shifting
    in_data = 8'd255; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 1);
    check("in_ready_in_shift", 32'(in_ready), 0);
    wait_valid(lat);
    check("lat_255", 32'(lat), 8);
    check("bcd_255", 32'(out_bcd), 32'h255);
    @(posedge clk); #1;
    check("idle_after_255", 32'(out_valid), 0);

    for (int i = 0; i < 8; i++) begin
      convert(vecs[i].value, res, lat);
      check("table_bcd", 32'(res), 32'(vecs[i].bcd));
      check("table_lat", 32'(lat), 8);
    end

    // back-to-back stream with in_valid held
    seq_in[0] = 8'd94; seq_in[1] = 8'd0; seq_in[2] = 8'd123;
    seq_exp[0] = 12'h094; seq_exp[1] = 12'h000; seq_exp[2] = 12'h123;
    in_data = seq_in[0]; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(lat);
      check("b2b_lat", 32'(lat), 8);
      check("b2b_bcd", 32'(out_bcd), 32'(seq_exp[k]));
      check("b2b_in_ready", 32'(in_ready), 1);
      if (k < 2) in_data = seq_in[k+1];
      else       in_valid = 1'b0;
      @(posedge clk); #1;
      if (k < 2) check("b2b_no_bubble", 32'(busy), 1);
      else       check("b2b_end_idle", 32'(out_valid), 0);
    end

    // backpressure on 45
    in_data = 8'd45; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_lat", 32'(lat), 8);
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_bcd !== 12'h045 || in_ready !== 1'b0) stable = 1'b0;
    end
    check("bp_hold_stable", 32'(stable), 1);
    out_ready = 1'b1;
    #1 check("bp_in_ready_comb", 32'(in_ready), 1);
    @(posedge clk); #1;
    check("bp_released", 32'(out_valid), 0);
    @(posedge clk); #1;
    check("bp_single_transfer", 32'(out_valid), 0);
    check("bp_bcd_kept", 32'(out_bcd), 32'h045);

    // in_data changes during SHIFT
    in_data = 8'd22; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_data = 8'd87;
    wait_valid(lat);
    check("chg_bcd_22", 32'(out_bcd), 32'h022);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("chg_87_accepted", 32'(busy), 1);
    wait_valid(lat);
    check("chg_lat_87", 32'(lat), 8);
    check("chg_bcd_87", 32'(out_bcd), 32'h087);
    @(posedge clk); #1;

    // reset in the middle of converting 111
    in_data = 8'd111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_out_bcd", 32'(out_bcd), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    convert(8'd68, res, lat);
    check("post_rst_bcd_68", 32'(res), 32'h068);
    check("post_rst_lat_68", 32'(lat), 8);

    for (int v = 0; v < 256; v++) begin
      convert(8'(v), res, lat);
      check("sweep", 32'(res), 32'(ref_bcd(v)));
    end

    // 10-bit build
    w_in_data = 10'd1023; w_in_valid = 1'b1;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    lat = 0;
    while (w_out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("wide_lat", 32'(lat), 10);
    check("wide_bcd_1023", 32'(w_out_bcd), 32'h1023);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
- Multi-cycle binary-to-BCD converter controller; sequences a shift-and-add-3 (double-dabble) datapath one bit per clock.
- Replaces the flat combinational converter where area matters or several values stream through one resource.
- Valid/ready handshake on input and output; sits between a binary producer (counter, ALU result) and a BCD consumer (display driver, UART formatter).

Parameters:
- BIN_W, 8, width of the binary input; legal range 4..16.
- DIGITS, 3, number of BCD digits out; must satisfy 10^DIGITS > 2^BIN_W - 1 (elaboration-time check, fatal if violated).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a value on in_data.
- in_ready  out  1  converter can accept; transfer on a clk edge when in_valid & in_ready.
- in_data  in  BIN_W  unsigned binary value.
- out_valid  out  1  out_bcd holds a completed result.
- out_ready  in  1  consumer accepts; transfer on a clk edge when out_valid & out_ready.
- out_bcd  out  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0].
- busy  out  1  high while in SHIFT state.

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_valid=0, busy=0, out_bcd=0, bit counter=0, shift register=0. in_ready=1 once reset deasserts.
- FSM states IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid, load shift register {BCD field=0, binary field=in_data}, clear counter, go to SHIFT.
- SHIFT: busy=1, in_ready=0, in_valid ignored.
  - Each cycle: every BCD digit >= 5 gets +3 (all digits corrected in parallel from current values), then the whole register shifts left by 1.
  - Counter increments per cycle. On the BIN_W-th shift, register the BCD field into out_bcd and go to DONE.
- DONE: out_valid=1; out_bcd stable until the output transfer.
  - out_ready=0: hold DONE indefinitely (backpressure); out_bcd and out_valid must not change.
  - out_ready=1 and in_valid=0: out_valid falls next cycle, go to IDLE.
  - out_ready=1 and in_valid=1: both transfers occur on the same edge; the new value loads and the FSM goes directly to SHIFT (no idle bubble).
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational path from out_ready; documented and accepted.
- Latency: out_valid rises exactly BIN_W cycles after the input acceptance edge (8 for default). Throughput with out_ready tied high: one result per BIN_W+1 cycles.
- in_data is sampled only on the acceptance edge; later changes have no effect on the conversion in flight.
- Arithmetic:
  - Shift register width is 4*DIGITS + BIN_W.
  - Per-digit correction is 4-bit with no carry between digits; the add-3 rule guarantees no digit exceeds 9 after the shift.
  - Unused top digits for a given value read 0.
- Reset mid-operation (any state) aborts the conversion, drops out_valid immediately (async), and returns to IDLE. No partial result is ever presented.
- out_bcd keeps its last value after the output transfer until the next completion. Consumers must qualify it with out_valid.

Decomposition:
- Package bcd_pkg:
  - state enum (IDLE, SHIFT, DONE).
  - constant ADD3_THRESH = 4'd5, ADD3_VAL = 4'd3.
  - function computing the minimum DIGITS for a given BIN_W, used in the elaboration check.
- Sub-module bcd_add3_digit: combinational 4-bit in/out (digit >= 5 ? digit+3 : digit), instantiated DIGITS times in a generate loop.
- FSM, counter, shift register and handshake logic live in the top module.

Test Plan:
- in_data=255, out_ready=1 -> out_valid exactly 8 cycles after acceptance, out_bcd=12'b0010_0101_0101.
- in_data=94, then 0, then 123 issued back-to-back with in_valid held and out_ready=1 -> 0x094, 0x000, 0x123 in order; new acceptance on each result's transfer edge, no idle bubble.
- in_data=45 with out_ready=0 for 20 cycles after completion -> out_valid stays 1, out_bcd=0x045 stable, in_ready=0; release out_ready -> single transfer, then IDLE.
- Change in_data from 22 to 87 during SHIFT with in_valid=1 -> result 0x022; 87 accepted only after the 0x022 transfer, producing 0x087.
- Assert rst_n=0 at cycle 4 of a conversion of 111 -> out_valid, busy and out_bcd go to 0 immediately; after release, a conversion of 68 yields 0x068 with correct latency.
- Exhaustive sweep 0..255 checked against a reference model (digit i = (v/10^i)%10) -> zero mismatches; BIN_W=10, DIGITS=4 build with 1023 -> 0x1023.
